// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types: stage occupancy states and the default bubble payload.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // All-zero word shown on an empty stage; decodes as a MIPS NOP (sll $0,$0,0).
    localparam logic [63:0] NOP_INSN = 64'h0;

    localparam int FLUSH_CNT_W = 16;

    function automatic logic [1:0] state_count(stage_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle around one pipe_skid_stage: upstream, downstream and control.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              stall;
    logic              flush;
    logic [1:0]        occupancy;
    logic [15:0]       flush_count;

    modport master (
        output in_valid, in_data, in_pc, out_ready, stall, flush,
        input  in_ready, out_valid, out_data, out_pc, occupancy, flush_count
    );

    modport slave (
        input  in_valid, in_data, in_pc, out_ready, stall, flush,
        output in_ready, out_valid, out_data, out_pc, occupancy, flush_count
    );
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry register: load enable, synchronous clear, clear wins over load.
module pipe_slot #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: head slot drives the outputs, skid slot absorbs one extra
// entry so upstream ready depends only on registered state.
module pipe_skid_stage
    import mips_pipe_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter int                PC_W    = 64,
    parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(NOP_INSN),
    parameter int                FLUSH_W = FLUSH_CNT_W
) (
    input  logic              p_clk,
    input  logic              p_reset,
    input  logic              p_in_valid,
    output logic              p_in_ready,
    input  logic [DATA_W-1:0] p_in_data,
    input  logic [PC_W-1:0]   p_in_pc,
    output logic              p_out_valid,
    input  logic              p_out_ready,
    output logic [DATA_W-1:0] p_out_data,
    output logic [PC_W-1:0]   p_out_pc,
    input  logic              p_stall,
    input  logic              p_flush,
    output logic [1:0]        p_occupancy,
    output logic [15:0]       p_flush_count
);
    localparam int                 SLOT_W    = DATA_W + PC_W;
    localparam logic [FLUSH_W-1:0] FLUSH_MAX = '1;

    stage_state_e       state_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [FLUSH_W-1:0] flush_cnt_reg;

    logic               push;
    logic               pop;
    logic               push_ok;
    logic               pop_ok;
    logic [FLUSH_W:0]   flush_sum;

    logic [SLOT_W-1:0]  slot_d    [2];
    logic               slot_load [2];
    logic [SLOT_W-1:0]  slot_q    [2];

    assign push    = p_in_valid & in_ready_reg;
    assign pop     = out_valid_reg & p_out_ready & ~p_stall;
    assign push_ok = push & ~p_flush;
    assign pop_ok  = pop & ~p_flush;

    // Slot 0 is the head, slot 1 the skid. FULL never pushes (ready is low).
    always_comb begin
        slot_d[0]    = {p_in_pc, p_in_data};
        slot_d[1]    = {p_in_pc, p_in_data};
        slot_load[0] = 1'b0;
        slot_load[1] = 1'b0;
        case (state_reg)
            ST_EMPTY: slot_load[0] = push_ok;
            ST_HALF: begin
                slot_load[0] = push_ok & pop_ok;
                slot_load[1] = push_ok & ~pop_ok;
            end
            ST_FULL: begin
                slot_d[0]    = slot_q[1];
                slot_load[0] = pop_ok;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            pipe_slot #(.W(SLOT_W)) u_slot (
                .clk   (p_clk),
                .srst  (p_reset),
                .load  (slot_load[gi]),
                .clear (p_flush),
                .d     (slot_d[gi]),
                .q     (slot_q[gi])
            );
        end
    endgenerate

    assign flush_sum = {1'b0, flush_cnt_reg} + (FLUSH_W + 1)'(state_count(state_reg));

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            flush_cnt_reg <= '0;
        end else if (p_flush) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            flush_cnt_reg <= flush_sum[FLUSH_W] ? FLUSH_MAX : flush_sum[FLUSH_W-1:0];
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (push) begin
                        state_reg     <= ST_HALF;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_HALF: begin
                    if (push && !pop) begin
                        state_reg    <= ST_FULL;
                        in_ready_reg <= 1'b0;
                    end else if (pop && !push) begin
                        state_reg     <= ST_EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_reg    <= ST_HALF;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign p_in_ready    = in_ready_reg;
    assign p_out_valid   = out_valid_reg;
    assign p_occupancy   = state_count(state_reg);
    assign p_out_data    = (state_reg == ST_EMPTY) ? BUBBLE : slot_q[0][DATA_W-1:0];
    assign p_out_pc      = (state_reg == ST_EMPTY) ? '0 : slot_q[0][SLOT_W-1:DATA_W];
    assign p_flush_count = 16'(flush_cnt_reg);
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage; a narrow-counter twin shares the stimulus
// so flush-count saturation is reachable in a few cycles.
module tb_pipe_skid_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_fc;

    pipe_skid_stage_if #(.DATA_W(64), .PC_W(64)) bus ();

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [63:0] sat_out_data;
    logic [63:0] sat_out_pc;
    logic [1:0]  sat_occupancy;
    logic [15:0] sat_flush_count;

    pipe_skid_stage dut (
        .p_clk         (clk),
        .p_reset       (rst),
        .p_in_valid    (bus.in_valid),
        .p_in_ready    (bus.in_ready),
        .p_in_data     (bus.in_data),
        .p_in_pc       (bus.in_pc),
        .p_out_valid   (bus.out_valid),
        .p_out_ready   (bus.out_ready),
        .p_out_data    (bus.out_data),
        .p_out_pc      (bus.out_pc),
        .p_stall       (bus.stall),
        .p_flush       (bus.flush),
        .p_occupancy   (bus.occupancy),
        .p_flush_count (bus.flush_count)
    );

    pipe_skid_stage #(.FLUSH_W(4)) dut_sat (
        .p_clk         (clk),
        .p_reset       (rst),
        .p_in_valid    (bus.in_valid),
        .p_in_ready    (sat_in_ready),
        .p_in_data     (bus.in_data),
        .p_in_pc       (bus.in_pc),
        .p_out_valid   (sat_out_valid),
        .p_out_ready   (bus.out_ready),
        .p_out_data    (sat_out_data),
        .p_out_pc      (sat_out_pc),
        .p_stall       (bus.stall),
        .p_flush       (bus.flush),
        .p_occupancy   (sat_occupancy),
        .p_flush_count (sat_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] d, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        offer(64'h77, 64'h700);
        bus.out_ready = 1'b1;
        bus.stall     = 1'b0;
        bus.flush     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        n_checks++; if (bus.out_pc !== 64'h0) begin n_fail++; $display("FAIL reset_out_pc got %h exp 0", bus.out_pc); end
        n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d exp 0", bus.occupancy); end
        n_checks++; if (bus.flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_flush_count got %0d exp 0", bus.flush_count); end
        $display("reset: in_ready=%b out_valid=%b occ=%0d fc=%0d", bus.in_ready, bus.out_valid, bus.occupancy, bus.flush_count);
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        offer(64'h11, 64'h100);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b exp 1", bus.out_valid); end
        n_checks++; if (bus.out_data !== 64'h11) begin n_fail++; $display("FAIL lat_data got %h exp 11", bus.out_data); end
        n_checks++; if (bus.out_pc !== 64'h100) begin n_fail++; $display("FAIL lat_pc got %h exp 100", bus.out_pc); end
        tick();
        n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL lat_drain_occ got %0d exp 0", bus.occupancy); end
        $display("latency: push 0x11 seen next cycle data=%h pc=%h", 64'h11, 64'h100);
    endtask

    task automatic test_fill_drain();
        bus.out_ready = 1'b0;
        offer(64'hA, 64'hA0);
        tick();
        offer(64'hB, 64'hB0);
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL full_occ got %0d exp 2", bus.occupancy); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
        n_checks++; if (bus.out_data !== 64'hA) begin n_fail++; $display("FAIL full_head got %h exp a", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_data !== 64'hB || bus.out_pc !== 64'hB0) begin n_fail++; $display("FAIL drain_second got %h/%h exp b/b0", bus.out_data, bus.out_pc); end
        n_checks++; if (bus.occupancy !== 2'd1) begin n_fail++; $display("FAIL drain_occ got %0d exp 1", bus.occupancy); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", bus.out_valid); end
        $display("fill_drain: 0xA then 0xB drained in order");
    endtask

    task automatic test_stream();
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        while (rx < 100 && cyc < 2000) begin
            bus.in_valid  = (tx < 100);
            bus.in_data   = 64'(tx);
            bus.in_pc     = 64'(tx * 4);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (bus.out_data !== 64'(rx) || bus.out_pc !== 64'(rx * 4)) begin
                    n_fail++;
                    $display("FAIL stream_order got %0d/%0h exp %0d/%0h", bus.out_data, bus.out_pc, rx, rx * 4);
                end
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++; if (rx != 100) begin n_fail++; $display("FAIL stream_timeout got %0d entries exp 100", rx); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra got valid=%b exp 0", bus.out_valid); end
        $display("stream: %0d entries in %0d cycles", rx, cyc);
    endtask

    task automatic test_flush_full();
        bus.out_ready = 1'b0;
        offer(64'h21, 64'h210);
        tick();
        offer(64'h22, 64'h220);
        tick();
        offer(64'h99, 64'h990);
        bus.flush = 1'b1;
        tick();
        exp_fc += 2;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", bus.occupancy); end
        n_checks++; if (bus.out_data !== 64'h0 || bus.out_pc !== 64'h0) begin n_fail++; $display("FAIL flush_bubble got %h/%h exp 0/0", bus.out_data, bus.out_pc); end
        n_checks++; if (bus.flush_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL flush_count got %0d exp %0d", bus.flush_count, exp_fc); end
        bus.out_ready = 1'b1;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_offer_leaked got valid=%b data=%h exp 0", bus.out_valid, bus.out_data); end
        $display("flush_full: fc=%0d", bus.flush_count);
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        offer(64'h5, 64'h50);
        tick();
        bus.stall     = 1'b1;
        bus.out_ready = 1'b1;
        offer(64'h6, 64'h60);
        tick();
        offer(64'h77, 64'h770);
        tick();
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_data !== 64'h5) begin n_fail++; $display("FAIL stall_head got %h exp 5", bus.out_data); end
        n_checks++; if (bus.occupancy !== 2'd2) begin n_fail++; $display("FAIL stall_occ got %0d exp 2", bus.occupancy); end
        bus.stall = 1'b0;
        tick();
        n_checks++; if (bus.out_data !== 64'h6 || bus.out_pc !== 64'h60) begin n_fail++; $display("FAIL stall_release got %h/%h exp 6/60", bus.out_data, bus.out_pc); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b exp 0", bus.out_valid); end
        $display("stall: 0x5 held, 0x6 accepted under stall");
    endtask

    task automatic test_stall_flush();
        bus.out_ready = 1'b0;
        offer(64'h5, 64'h50);
        tick();
        offer(64'h66, 64'h660);
        bus.stall     = 1'b1;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        tick();
        exp_fc += 1;
        bus.in_valid = 1'b0;
        bus.stall    = 1'b0;
        n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL stallflush_occ got %0d exp 0", bus.occupancy); end
        n_checks++; if (bus.flush_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL stallflush_count got %0d exp %0d", bus.flush_count, exp_fc); end
        tick();
        bus.flush = 1'b0;
        n_checks++; if (bus.flush_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL emptyflush_count got %0d exp %0d", bus.flush_count, exp_fc); end
        $display("stall_flush: fc=%0d", bus.flush_count);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        offer(64'h31, 64'h310);
        tick();
        offer(64'h32, 64'h320);
        tick();
        rst       = 1'b1;
        bus.flush = 1'b1;
        offer(64'h33, 64'h330);
        tick();
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_fc       = 0;
        n_checks++; if (bus.occupancy !== 2'd0) begin n_fail++; $display("FAIL rstmid_occ got %0d exp 0", bus.occupancy); end
        n_checks++; if (bus.flush_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", bus.flush_count); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
        $display("reset_mid: occ=%0d fc=%0d", bus.occupancy, bus.flush_count);
    endtask

    task automatic flush_from_full();
        bus.out_ready = 1'b0;
        offer(64'h41, 64'h410);
        tick();
        offer(64'h42, 64'h420);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        exp_fc += 2;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 7; i++) flush_from_full();
        n_checks++; if (sat_flush_count !== 16'hE) begin n_fail++; $display("FAIL sat_preload got %h exp e", sat_flush_count); end
        n_checks++; if (bus.flush_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL wide_preload got %0d exp %0d", bus.flush_count, exp_fc); end
        flush_from_full();
        n_checks++; if (sat_flush_count !== 16'hF) begin n_fail++; $display("FAIL sat_reach got %h exp f", sat_flush_count); end
        n_checks++; if (bus.flush_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL wide_count got %0d exp %0d", bus.flush_count, exp_fc); end
        flush_from_full();
        n_checks++; if (sat_flush_count !== 16'hF) begin n_fail++; $display("FAIL sat_hold got %h exp f", sat_flush_count); end
        n_checks++; if (bus.flush_count !== 16'(exp_fc)) begin n_fail++; $display("FAIL wide_count2 got %0d exp %0d", bus.flush_count, exp_fc); end
        $display("saturation: narrow=%h wide=%0d", sat_flush_count, bus.flush_count);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        exp_fc        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        test_reset();
        test_latency();
        test_fill_drain();
        test_stream();
        test_flush_full();
        test_stall();
        test_stall_flush();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
